// File: rtl/bcd_counter4_pkg.sv
// ---------------------------------------------------------------------------
// bcd_counter4_pkg: shared BCD digit constants, types and load clamp. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package bcd_counter4_pkg;

    localparam int          BCD_DIGIT_W = 4;
    localparam logic [3:0]  BCD_MAX     = 4'd9;
    localparam int          NUM_DIGITS  = 4;

    typedef logic [BCD_DIGIT_W-1:0] digit_t;

    // Anything above 9 is not a decimal digit; saturate it to 9.
    function automatic digit_t bcd_clamp(input digit_t d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_counter4_digit.sv
// ---------------------------------------------------------------------------
// bcd_digit: one decade of the up/down BCD counter with carry/borrow out. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bcd_digit
    import bcd_counter4_pkg::*;
(
    input  logic   Clock,
    input  logic   Reset,
    input  logic   clear,
    input  logic   load,
    input  digit_t load_val,
    input  logic   step_in,
    input  logic   up,
    output digit_t digit,
    output logic   step_out
);

    digit_t digit_reg;

    // A step leaves this decade exactly when it rolls over in the chosen direction.
    assign step_out = step_in && (up ? (digit_reg == BCD_MAX) : (digit_reg == '0));
    assign digit    = digit_reg;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            digit_reg <= '0;
        end else if (clear) begin
            digit_reg <= '0;
        end else if (load) begin
            digit_reg <= bcd_clamp(load_val);
        end else if (step_in) begin
            if (up) begin
                digit_reg <= (digit_reg >= BCD_MAX) ? digit_t'(0) : digit_reg + digit_t'(1);
            end else begin
                digit_reg <= (digit_reg == '0) ? BCD_MAX : digit_reg - digit_t'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/bcd_counter4.sv
// ---------------------------------------------------------------------------
// bcd_counter4: four-decade BCD up/down counter with prescaler, Tick and Wrap. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bcd_counter4
    import bcd_counter4_pkg::*;
#(
    parameter int PRESCALE   = 50000000,
    parameter int PRESCALE_W = 26
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Enable,
    input  logic        Up,
    input  logic        Clear,
    input  logic        Load,
    input  logic [15:0] LoadValue,
    output logic [15:0] Q,
    output logic        Tick,
    output logic        Wrap
);

    logic [PRESCALE_W-1:0] prescaler;
    logic                  pre_last;
    logic                  step;
    logic [NUM_DIGITS:0]   step_chain;

    assign pre_last = (prescaler == PRESCALE_W'(PRESCALE - 1));
    // Clear and load take priority, so they suppress the step entirely.
    assign step     = Enable && pre_last && !Clear && !Load;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            prescaler <= '0;
        end else if (Clear || Load) begin
            prescaler <= '0;
        end else if (Enable) begin
            prescaler <= pre_last ? '0 : prescaler + PRESCALE_W'(1);
        end
    end

    assign step_chain[0] = step;

    generate
        for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
            bcd_digit u_digit (
                .Clock    (Clock),
                .Reset    (Reset),
                .clear    (Clear),
                .load     (Load),
                .load_val (LoadValue[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .step_in  (step_chain[i]),
                .up       (Up),
                .digit    (Q[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .step_out (step_chain[i+1])
            );
        end
    endgenerate

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Tick <= 1'b0;
            Wrap <= 1'b0;
        end else begin
            Tick <= step;
            Wrap <= step_chain[NUM_DIGITS];
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bcd_counter4.sv
// ---------------------------------------------------------------------------
// tb_bcd_counter4: directed checks on PRESCALE=1 and PRESCALE=4 instances. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_bcd_counter4;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_a, up_a, clr_a, ld_a;
    logic [15:0] lv_a, q_a;
    logic        tick_a, wrap_a;
    logic        en_b, up_b, clr_b, ld_b;
    logic [15:0] lv_b, q_b;
    logic        tick_b, wrap_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bcd_counter4 #(.PRESCALE(1), .PRESCALE_W(2)) dut_a (
        .Clock(clk), .Reset(rst), .Enable(en_a), .Up(up_a), .Clear(clr_a),
        .Load(ld_a), .LoadValue(lv_a), .Q(q_a), .Tick(tick_a), .Wrap(wrap_a)
    );

    bcd_counter4 #(.PRESCALE(4), .PRESCALE_W(3)) dut_b (
        .Clock(clk), .Reset(rst), .Enable(en_b), .Up(up_b), .Clear(clr_b),
        .Load(ld_b), .LoadValue(lv_b), .Q(q_b), .Tick(tick_b), .Wrap(wrap_b)
    );

    task automatic drive_edge();
        @(negedge clk);
    endtask

    task automatic sample_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_tests++;
        if (q_a !== 16'h0000 || tick_a !== 1'b0 || wrap_a !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_a: q=%h tick=%b wrap=%b, want 0000 0 0", q_a, tick_a, wrap_a);
        end
        n_tests++;
        if (q_b !== 16'h0000 || tick_b !== 1'b0 || wrap_b !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_b: q=%h tick=%b wrap=%b, want 0000 0 0", q_b, tick_b, wrap_b);
        end
        drive_edge();
        rst = 1'b0;
    endtask

    task automatic test_count_after_midreset();
        logic [15:0] exp_q [12] = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006,
                                    16'h0007, 16'h0008, 16'h0009, 16'h0010, 16'h0011, 16'h0012};
        en_a = 1'b1;
        up_a = 1'b1;
        repeat (5) sample_edge();
        drive_edge();
        rst = 1'b1;
        #1;
        n_tests++;
        if (q_a !== 16'h0000 || tick_a !== 1'b0 || wrap_a !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_async: q=%h tick=%b wrap=%b, want 0000 0 0", q_a, tick_a, wrap_a);
        end
        sample_edge();
        n_tests++;
        if (q_a !== 16'h0000 || tick_a !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_hold: q=%h tick=%b, want 0000 0", q_a, tick_a);
        end
        drive_edge();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            sample_edge();
            n_tests++;
            if (q_a !== exp_q[i] || tick_a !== 1'b1 || wrap_a !== 1'b0) begin
                n_fail++;
                $display("FAIL count_up[%0d]: q=%h tick=%b wrap=%b, want %h 1 0",
                         i, q_a, tick_a, wrap_a, exp_q[i]);
            end
        end
    endtask

    task automatic test_wrap_up();
        logic [15:0] exp_q [4] = '{16'h9998, 16'h9999, 16'h0000, 16'h0001};
        logic        exp_t [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic        exp_w [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        drive_edge();
        ld_a = 1'b1;
        lv_a = 16'h9998;
        up_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sample_edge();
            n_tests++;
            if (q_a !== exp_q[i] || tick_a !== exp_t[i] || wrap_a !== exp_w[i]) begin
                n_fail++;
                $display("FAIL wrap_up[%0d]: q=%h tick=%b wrap=%b, want %h %b %b",
                         i, q_a, tick_a, wrap_a, exp_q[i], exp_t[i], exp_w[i]);
            end
            if (i == 0) begin
                drive_edge();
                ld_a = 1'b0;
            end
        end
    endtask

    task automatic test_wrap_down();
        logic [15:0] exp_q [4] = '{16'h0001, 16'h0000, 16'h9999, 16'h9998};
        logic        exp_w [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        drive_edge();
        ld_a = 1'b1;
        lv_a = 16'h0001;
        up_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sample_edge();
            n_tests++;
            if (q_a !== exp_q[i] || wrap_a !== exp_w[i] || tick_a !== (i != 0)) begin
                n_fail++;
                $display("FAIL wrap_down[%0d]: q=%h tick=%b wrap=%b, want %h %b %b",
                         i, q_a, tick_a, wrap_a, exp_q[i], (i != 0), exp_w[i]);
            end
            if (i == 0) begin
                drive_edge();
                ld_a = 1'b0;
            end
        end
        drive_edge();
        ld_a = 1'b1;
        lv_a = 16'h0100;
        sample_edge();
        drive_edge();
        ld_a = 1'b0;
        sample_edge();
        n_tests++;
        if (q_a !== 16'h0099 || tick_a !== 1'b1 || wrap_a !== 1'b0) begin
            n_fail++;
            $display("FAIL borrow_0100: q=%h tick=%b wrap=%b, want 0099 1 0", q_a, tick_a, wrap_a);
        end
    endtask

    task automatic test_clamp_and_priority();
        drive_edge();
        en_a = 1'b0;
        ld_a = 1'b1;
        lv_a = 16'hFA5C;
        sample_edge();
        n_tests++;
        if (q_a !== 16'h9959 || tick_a !== 1'b0) begin
            n_fail++;
            $display("FAIL load_clamp: q=%h tick=%b, want 9959 0", q_a, tick_a);
        end
        drive_edge();
        lv_a  = 16'h1234;
        clr_a = 1'b1;
        sample_edge();
        n_tests++;
        if (q_a !== 16'h0000 || tick_a !== 1'b0 || wrap_a !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_over_load: q=%h tick=%b wrap=%b, want 0000 0 0", q_a, tick_a, wrap_a);
        end
        drive_edge();
        clr_a = 1'b0;
        ld_a  = 1'b0;
    endtask

    task automatic test_prescale_enable();
        logic [15:0] exp_q;
        logic        exp_t;
        en_b = 1'b1;
        up_b = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            sample_edge();
            exp_t = (k == 4 || k == 8);
            exp_q = (k >= 8) ? 16'h0002 : (k >= 4) ? 16'h0001 : 16'h0000;
            n_tests++;
            if (q_b !== exp_q || tick_b !== exp_t || wrap_b !== 1'b0) begin
                n_fail++;
                $display("FAIL prescale_run[%0d]: q=%h tick=%b wrap=%b, want %h %b 0",
                         k, q_b, tick_b, wrap_b, exp_q, exp_t);
            end
        end
        drive_edge();
        en_b = 1'b0;
        for (int k = 0; k < 5; k++) begin
            // Toggling Up while idle must not disturb the count.
            up_b = ~up_b;
            sample_edge();
            n_tests++;
            if (q_b !== 16'h0002 || tick_b !== 1'b0) begin
                n_fail++;
                $display("FAIL prescale_hold[%0d]: q=%h tick=%b, want 0002 0", k, q_b, tick_b);
            end
            drive_edge();
        end
        up_b = 1'b1;
        en_b = 1'b1;
        sample_edge();
        n_tests++;
        if (q_b !== 16'h0002 || tick_b !== 1'b0) begin
            n_fail++;
            $display("FAIL reenable_1: q=%h tick=%b, want 0002 0", q_b, tick_b);
        end
        sample_edge();
        n_tests++;
        if (q_b !== 16'h0003 || tick_b !== 1'b1) begin
            n_fail++;
            $display("FAIL reenable_2: q=%h tick=%b, want 0003 1", q_b, tick_b);
        end
    endtask

    task automatic test_clear_prescaler();
        repeat (2) sample_edge();
        drive_edge();
        en_b  = 1'b0;
        clr_b = 1'b1;
        sample_edge();
        n_tests++;
        if (q_b !== 16'h0000 || tick_b !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_disabled: q=%h tick=%b, want 0000 0", q_b, tick_b);
        end
        drive_edge();
        clr_b = 1'b0;
        en_b  = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            sample_edge();
            n_tests++;
            if (q_b !== ((k == 4) ? 16'h0001 : 16'h0000) || tick_b !== (k == 4)) begin
                n_fail++;
                $display("FAIL clear_restart[%0d]: q=%h tick=%b, want %h %b",
                         k, q_b, tick_b, ((k == 4) ? 16'h0001 : 16'h0000), (k == 4));
            end
        end
    endtask

    initial begin
        rst  = 1'b1;
        en_a = 1'b0; up_a = 1'b1; clr_a = 1'b0; ld_a = 1'b0; lv_a = 16'h0000;
        en_b = 1'b0; up_b = 1'b1; clr_b = 1'b0; ld_b = 1'b0; lv_b = 16'h0000;
        test_reset();
        test_count_after_midreset();
        test_wrap_up();
        test_wrap_down();
        test_clamp_and_priority();
        test_prescale_enable();
        test_clear_prescaler();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bcd_counter4.md
Name: bcd_counter4

Overview:
- Four-decade synchronous BCD up/down counter with a built-in prescaler.
- Produces the packed 16-bit value Q[15:0] that drives the four hexto7segment digit decoders. Q[3:0] goes to HEX0 and Q[15:12] goes to HEX3.
- Each digit stays in the range 0-9, so the displays only ever show decimal 0000-9999.
- Provides enable, direction, clear, parallel load, and a wrap (carry/borrow) pulse.

Parameters:
- PRESCALE, 50000000: number of enabled clock cycles per count step. Value 1 means step on every enabled cycle.
- PRESCALE_W, 26: width of the prescaler register. Must satisfy 2**PRESCALE_W >= PRESCALE.

Ports:
- Clock  input  1  single system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Enable  input  1  1 = prescaler and counter run; 0 = everything holds.
- Up  input  1  1 = count up, 0 = count down. Sampled on each step.
- Clear  input  1  synchronous clear of count and prescaler.
- Load  input  1  synchronous parallel load of LoadValue.
- LoadValue  input  16  four packed BCD digits; [3:0] is the least significant digit.
- Q  output  16  current count, four packed BCD digits.
- Tick  output  1  registered one-cycle pulse on each count step.
- Wrap  output  1  registered one-cycle pulse when a step wraps 9999->0000 (up) or 0000->9999 (down).

Behaviour:
- Reset is asynchronous and active-high, and may arrive mid-operation. While Reset is high: Q=16'h0000, prescaler=0, Tick=0, Wrap=0. Operation resumes on the first rising Clock edge after Reset deasserts.
- Priority at each rising edge: Clear > Load > step > hold.
- Clear:
  - Q<=0, prescaler<=0, Tick<=0, Wrap<=0.
  - Applies regardless of Enable.
- Load:
  - Q<=LoadValue, with each nibble >9 clamped to 9 (e.g. 16'h3A7F loads as 16'h3979).
  - prescaler<=0; Tick<=0; Wrap<=0.
  - Applies regardless of Enable.
- Prescaler:
  - When Enable=1, it counts 0..PRESCALE-1 and then wraps to 0.
  - A step occurs on the edge where Enable=1 and prescaler==PRESCALE-1.
  - When Enable=0, the prescaler holds its value and is not reset.
- Step up:
  - Digit 0 increments. A digit at 9 becomes 0 and propagates a carry to the next digit.
  - 9999 -> 0000 with Wrap=1.
- Step down:
  - Digit 0 decrements. A digit at 0 becomes 9 and propagates a borrow to the next digit.
  - 0000 -> 9999 with Wrap=1.
- Latency and pulse timing:
  - Q changes on the step edge.
  - Tick=1 during the cycle following the step edge, i.e. coincident with the new Q.
  - Wrap uses the same timing as Tick. Both are 0 in all other cycles.
- Direction change: Up is sampled only at step edges. Toggling Up between steps has no effect on Q.
- Enable deasserted exactly on the would-be step edge: no step occurs, and Q, Tick and Wrap do not fire.
- Invariant: each nibble of Q is always in the range 0-9 after reset, clear, load or step.

Decomposition:
- Shared package:
  - BCD_DIGIT_W = 4
  - BCD_MAX = 4'd9
  - NUM_DIGITS = 4
  - digit typedef: logic [3:0]
- Sub-module bcd_digit, instantiated 4 times:
  - Inputs: Clock, Reset, clear, load, load_val, step_in, up.
  - Outputs: digit, step_out (carry/borrow to the next decade).
  - Each instance performs its own clamp on load.
- bcd_counter4 contains:
  - the prescaler
  - the ripple of step_out into step_in between digits
  - the Tick/Wrap registers, where Wrap = step_out of digit 3, registered

Test Plan:
- PRESCALE=1: assert Reset mid-count, then release; hold Enable=1, Up=1 for 12 cycles -> Q shows 0000 during reset, then 0001..0012 one per cycle; Tick high in each of those cycles; Wrap never high.
- PRESCALE=1: Load 16'h9998, then Enable=1, Up=1 -> Q goes 9998, 9999, 0000, 0001; Wrap high only in the cycle Q=0000.
- PRESCALE=1: Load 16'h0001, Up=0 -> Q goes 0000, 9999, 9998; Wrap high only in the cycle Q=9999. Load 16'h0100, step down -> 0099.
- PRESCALE=4: Enable=1 for 10 cycles, drop Enable for 5 cycles, then re-enable -> steps occur after enabled cycles 4 and 8; the next step comes 2 enabled cycles after re-enable; Q=0003 at that point.
- PRESCALE=1: Load LoadValue=16'hFA5C -> Q=16'h9959. Asserting Clear and Load in the same cycle -> Q=0000.
- PRESCALE=4: Clear asserted with Enable=0 when the prescaler is at 2 -> Q=0000; the next step comes exactly 4 enabled cycles later.
